// File: rtl/inst_fetch_queue.sv
// Fetch stage ahead of the icache: owns the PC, holds the fetch address across misses,
// and buffers fetched {pc, inst} pairs in a small FIFO for decode.
module inst_fetch_queue #(
    parameter int unsigned            ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = ADDR_WIDTH'(32'hBFC00000),
    parameter int unsigned            DEPTH_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  cache_read_en,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    input  logic                  cache_ready,
    input  logic [31:0]           cache_data,
    output logic                  inst_valid,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic [31:0]           inst_data,
    input  logic                  inst_ready,
    input  logic                  redirect_en,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
);

    localparam int unsigned DEPTH = 1 << DEPTH_WIDTH;
    localparam int unsigned CNT_W = DEPTH_WIDTH + 1;

    logic [ADDR_WIDTH-1:0]  r_pc;
    logic                   r_waiting;
    logic                   r_pend_valid;
    logic [ADDR_WIDTH-1:0]  r_pend_pc;
    logic [DEPTH_WIDTH-1:0] r_rd_ptr;
    logic [DEPTH_WIDTH-1:0] r_wr_ptr;
    logic [CNT_W-1:0]       r_count;
    logic [ADDR_WIDTH-1:0]  r_mem_pc   [DEPTH];
    logic [31:0]            r_mem_inst [DEPTH];

    logic                   w_not_full;
    logic                   w_accept;
    logic                   w_miss;
    logic                   w_push;
    logic                   w_pop;
    logic [ADDR_WIDTH-1:0]  w_redirect_aligned;

    assign w_not_full         = (r_count != CNT_W'(DEPTH));
    assign cache_read_en      = !rst && (r_waiting || w_not_full);
    assign cache_addr         = r_pc;
    assign inst_valid         = !rst && (r_count != '0);
    assign inst_pc            = r_mem_pc[r_rd_ptr];
    assign inst_data          = r_mem_inst[r_rd_ptr];

    assign w_accept           = cache_read_en && cache_ready;
    assign w_miss             = cache_read_en && !cache_ready;
    assign w_push             = w_accept && !r_pend_valid && !redirect_en;
    assign w_pop              = inst_valid && inst_ready && !redirect_en;
    assign w_redirect_aligned = redirect_pc & ~ADDR_WIDTH'(3);

    // Control state: PC, miss tracking, deferred redirect, FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_waiting    <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_pc    <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
        end else if (redirect_en) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            // An in-flight fill must finish on its original address before the PC moves
            if (r_waiting && !cache_ready) begin
                r_pend_valid <= 1'b1;
                r_pend_pc    <= w_redirect_aligned;
            end else begin
                r_pc         <= w_redirect_aligned;
                r_pend_valid <= 1'b0;
                r_waiting    <= 1'b0;
            end
        end else begin
            if (w_accept) begin
                r_waiting <= 1'b0;
                if (r_pend_valid) begin
                    r_pc         <= r_pend_pc;
                    r_pend_valid <= 1'b0;
                end else begin
                    r_pc <= r_pc + ADDR_WIDTH'(4);
                end
            end else if (w_miss) begin
                r_waiting <= 1'b1;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_WIDTH'(1);
            end

            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // FIFO storage needs no reset; validity lives in r_count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= r_pc;
            r_mem_inst[r_wr_ptr] <= cache_data;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: stimulus queues expected {pc, inst} pairs,
// a negedge monitor pops and compares whenever decode accepts the FIFO head.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cache_read_en;
    logic [31:0] cache_addr;
    logic        cache_ready = 1'b0;
    logic [31:0] cache_data;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        inst_ready = 1'b0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = '0;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] sb_pc [$];

    always #5 clk = ~clk;

    // Icache model: every word is the bitwise inverse of its address
    assign cache_data = ~cache_addr;

    inst_fetch_queue dut (
        .clk           (clk),
        .rst           (rst),
        .cache_read_en (cache_read_en),
        .cache_addr    (cache_addr),
        .cache_ready   (cache_ready),
        .cache_data    (cache_data),
        .inst_valid    (inst_valid),
        .inst_pc       (inst_pc),
        .inst_data     (inst_data),
        .inst_ready    (inst_ready),
        .redirect_en   (redirect_en),
        .redirect_pc   (redirect_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_push(input logic [31:0] pc);
        sb_pc.push_back(pc);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        cache_ready = 1'b0;
        inst_ready  = 1'b0;
        redirect_en = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_read_en", 32'(cache_read_en), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_drained(input string name);
        chk(name, 32'(sb_pc.size()), 32'd0);
        sb_pc.delete();
    endtask

    // Monitor: a handshake at the next posedge is decided by the values seen at this negedge
    always @(negedge clk) begin
        if (!rst && inst_valid && inst_ready && !redirect_en) begin
            if (sb_pc.size() == 0) begin
                chk("unexpected_pop_pc", inst_pc, 32'hxxxxxxxx);
            end else begin
                logic [31:0] exp_pc;
                exp_pc = sb_pc.pop_front();
                chk("pop_pc", inst_pc, exp_pc);
                chk("pop_data", inst_data, ~exp_pc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: streaming hits after reset
        do_reset();
        cache_ready = 1'b1; inst_ready = 1'b1;
        expect_push(32'hBFC00000);
        @(negedge clk);
        chk("t1_read_en", 32'(cache_read_en), 32'd1);
        chk("t1_first_valid", 32'(inst_valid), 32'd0);
        chk("t1_addr0", cache_addr, 32'hBFC00000);
        tick();
        expect_push(32'hBFC00004);
        @(negedge clk);
        chk("t1_valid_next", 32'(inst_valid), 32'd1);
        chk("t1_addr1", cache_addr, 32'hBFC00004);
        tick();
        expect_push(32'hBFC00008);
        tick();
        cache_ready = 1'b0;
        @(negedge clk);
        chk("t1_addr3", cache_addr, 32'hBFC0000C);
        tick();
        chk_drained("t1_drained");

        // 2: six-cycle miss then hit
        do_reset();
        cache_ready = 1'b0; inst_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t2_miss_read_en", 32'(cache_read_en), 32'd1);
            chk("t2_miss_addr", cache_addr, 32'hBFC00000);
            chk("t2_miss_valid", 32'(inst_valid), 32'd0);
            tick();
        end
        cache_ready = 1'b1;
        expect_push(32'hBFC00000);
        @(negedge clk);
        chk("t2_fill_addr", cache_addr, 32'hBFC00000);
        tick();
        cache_ready = 1'b0;
        @(negedge clk);
        chk("t2_next_addr", cache_addr, 32'hBFC00004);
        chk("t2_valid", 32'(inst_valid), 32'd1);
        tick();
        chk_drained("t2_drained");

        // 3: fill FIFO while decode stalls, then single pop
        do_reset();
        cache_ready = 1'b1; inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_push(32'hBFC00000 + 32'(4 * i));
            tick();
        end
        inst_ready = 1'b1;
        @(negedge clk);
        chk("t3_full_read_en", 32'(cache_read_en), 32'd0);
        chk("t3_full_addr", cache_addr, 32'hBFC00010);
        tick();
        inst_ready = 1'b0;
        expect_push(32'hBFC00010);
        @(negedge clk);
        chk("t3_resume_read_en", 32'(cache_read_en), 32'd1);
        chk("t3_resume_addr", cache_addr, 32'hBFC00010);
        tick();
        cache_ready = 1'b0; inst_ready = 1'b1;
        @(negedge clk);
        chk("t3_refull_addr", cache_addr, 32'hBFC00014);
        for (int i = 0; i < 4; i++) tick();
        @(negedge clk);
        chk("t3_empty_valid", 32'(inst_valid), 32'd0);
        tick();
        chk_drained("t3_drained");

        // 4: redirect flushes a 3-entry FIFO; low address bits forced to 0
        do_reset();
        cache_ready = 1'b1; inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        redirect_en = 1'b1; redirect_pc = 32'h80001003;
        @(negedge clk);
        chk("t4_pre_valid", 32'(inst_valid), 32'd1);
        tick();
        redirect_en = 1'b0; inst_ready = 1'b1;
        expect_push(32'h80001000);
        @(negedge clk);
        chk("t4_flushed_valid", 32'(inst_valid), 32'd0);
        chk("t4_addr", cache_addr, 32'h80001000);
        tick();
        cache_ready = 1'b0;
        @(negedge clk);
        chk("t4_next_addr", cache_addr, 32'h80001004);
        tick();
        chk_drained("t4_drained");

        // 5: redirect during an outstanding miss is deferred until the fill returns
        do_reset();
        cache_ready = 1'b1; inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            expect_push(32'hBFC00000 + 32'(4 * i));
            tick();
        end
        cache_ready = 1'b0;
        @(negedge clk);
        chk("t5_miss_addr", cache_addr, 32'hBFC00020);
        tick();
        redirect_en = 1'b1; redirect_pc = 32'h80002000;
        @(negedge clk);
        chk("t5_redir_addr", cache_addr, 32'hBFC00020);
        tick();
        redirect_en = 1'b0;
        @(negedge clk);
        chk("t5_held_addr", cache_addr, 32'hBFC00020);
        chk("t5_held_read_en", 32'(cache_read_en), 32'd1);
        tick();
        cache_ready = 1'b1;
        @(negedge clk);
        chk("t5_fill_addr", cache_addr, 32'hBFC00020);
        tick();
        cache_ready = 1'b0;
        @(negedge clk);
        chk("t5_target_addr", cache_addr, 32'h80002000);
        chk("t5_dropped_valid", 32'(inst_valid), 32'd0);
        tick();

        // 7: a newer redirect overwrites the pending one
        redirect_en = 1'b1; redirect_pc = 32'h80004000;
        tick();
        redirect_pc = 32'h80005008;
        tick();
        redirect_en = 1'b0; cache_ready = 1'b1;
        @(negedge clk);
        chk("t7_fill_addr", cache_addr, 32'h80002000);
        tick();
        cache_ready = 1'b0;
        @(negedge clk);
        chk("t7_target_addr", cache_addr, 32'h80005008);
        chk("t7_valid", 32'(inst_valid), 32'd0);
        tick();
        chk_drained("t5_drained");

        // 6: PC wraps from the top of the address space
        do_reset();
        cache_ready = 1'b0; inst_ready = 1'b1;
        redirect_en = 1'b1; redirect_pc = 32'hFFFFFFFC;
        tick();
        redirect_en = 1'b0; cache_ready = 1'b1;
        expect_push(32'hFFFFFFFC);
        @(negedge clk);
        chk("t6_addr_top", cache_addr, 32'hFFFFFFFC);
        tick();
        expect_push(32'h00000000);
        @(negedge clk);
        chk("t6_addr_wrap", cache_addr, 32'h00000000);
        tick();
        cache_ready = 1'b0;
        @(negedge clk);
        chk("t6_addr_after", cache_addr, 32'h00000004);
        tick();
        chk_drained("t6_drained");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
